jt900h_dmpctl: RTL and testbench



---
 rtl/jt900h_dmpctl_if.sv | 15 +
 rtl/jt900h_dmpctl.sv | 182 ++++++++++++++++++
 tb/tb_jt900h_dmpctl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt900h_dmpctl_if.sv
// Dump-port and byte-stream bundle between jt900h_dmpctl, the CPU register file and the stream sink.
// master: the dump controller; slave: register file plus sink side.
interface jt900h_dmpctl_if #(parameter int AW = 8);
    logic [AW-1:0] dmp_addr;
    logic [7:0]    dmp_dout;
    logic [7:0]    st_data;
    logic          st_valid;
    logic          st_ready;
    logic          st_last;

    modport master (output dmp_addr, st_data, st_valid, st_last,
                    input  dmp_dout, st_ready);
    modport slave  (input  dmp_addr, st_data, st_valid, st_last,
                    output dmp_dout, st_ready);
endinterface

// File: rtl/jt900h_dmpctl.sv
// Register-dump controller: arbitrates two dump requesters, halts the CPU and streams the register file bytewise.
// Optional JT900H_DMPCTL_CHKSUM_EN appends a two's-complement checksum byte after the last register byte.
//
// state | meaning
// IDLE  | no dump; arbitrate pending requests
// HALT  | grant held, waiting for the CPU to acknowledge the freeze
// CAPT  | latch the register byte at dmp_addr onto the stream
// STRM  | byte presented, waiting for the sink handshake
// FIN   | dump complete; release CPU and grant
module jt900h_dmpctl #(
    parameter int DMP_LAST = 81,
    parameter int AW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       halt,
    input  logic       halted,
    output logic       done,
    output logic       abort,
    jt900h_dmpctl_if.master dmp
);
    typedef enum logic [2:0] {IDLE, HALT, CAPT, STRM, FIN} state_t;

    localparam logic [AW-1:0] ADDR_LAST = AW'(DMP_LAST);

    state_t        state, state_nx;
    logic [1:0]    gnt_nx;
    logic          halt_nx, done_nx, abort_nx;
    logic [AW-1:0] addr, addr_nx;
    logic [7:0]    data, data_nx;
    logic          valid, valid_nx, last, last_nx;
    logic          rr, rr_nx;
    logic          drop, drop_nx;
    logic          req_live, hs;
`ifdef JT900H_DMPCTL_CHKSUM_EN
    logic [7:0]    sum, sum_nx;
    logic          chk, chk_nx;
`endif

    assign req_live     = |(req & gnt);
    assign hs           = valid & dmp.st_ready;
    assign dmp.dmp_addr = addr;
    assign dmp.st_data  = data;
    assign dmp.st_valid = valid;
    assign dmp.st_last  = last;

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        halt_nx  = halt;
        done_nx  = 1'b0;
        abort_nx = 1'b0;
        addr_nx  = addr;
        data_nx  = data;
        valid_nx = valid;
        last_nx  = last;
        rr_nx    = rr;
        drop_nx  = drop;
`ifdef JT900H_DMPCTL_CHKSUM_EN
        sum_nx   = sum;
        chk_nx   = chk;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    // rr=1 means requester 1 wins a tie
                    if (req == 2'b11) gnt_nx = rr ? 2'b10 : 2'b01;
                    else              gnt_nx = req;
                    halt_nx  = 1'b1;
                    addr_nx  = '0;
                    drop_nx  = 1'b0;
`ifdef JT900H_DMPCTL_CHKSUM_EN
                    sum_nx   = 8'd0;
                    chk_nx   = 1'b0;
`endif
                    state_nx = HALT;
                end
            end
            HALT: begin
                if (!req_live) begin
                    abort_nx = 1'b1;
                    halt_nx  = 1'b0;
                    gnt_nx   = 2'b00;
                    state_nx = IDLE;
                end else if (halted) begin
                    state_nx = CAPT;
                end
            end
            CAPT: begin
                valid_nx = 1'b1;
`ifdef JT900H_DMPCTL_CHKSUM_EN
                if (chk) begin
                    data_nx = 8'd0 - sum;
                    last_nx = 1'b1;
                end else begin
                    data_nx = dmp.dmp_dout;
                    sum_nx  = sum + dmp.dmp_dout;
                    last_nx = 1'b0;
                end
`else
                data_nx  = dmp.dmp_dout;
                last_nx  = (addr == ADDR_LAST);
`endif
                if (!req_live) drop_nx = 1'b1;
                state_nx = STRM;
            end
            STRM: begin
                // a dropped request is remembered so the presented byte still completes
                if (!req_live) drop_nx = 1'b1;
                if (hs) begin
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                    if (last) begin
                        state_nx = FIN;
                    end else if (drop || !req_live) begin
                        abort_nx = 1'b1;
                        halt_nx  = 1'b0;
                        gnt_nx   = 2'b00;
                        addr_nx  = '0;
                        state_nx = IDLE;
                    end else begin
`ifdef JT900H_DMPCTL_CHKSUM_EN
                        if (addr == ADDR_LAST) chk_nx  = 1'b1;
                        else                   addr_nx = addr + AW'(1);
`else
                        addr_nx = addr + AW'(1);
`endif
                        state_nx = CAPT;
                    end
                end
            end
            FIN: begin
                done_nx  = 1'b1;
                halt_nx  = 1'b0;
                gnt_nx   = 2'b00;
                rr_nx    = gnt[0];
                addr_nx  = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 2'b00;
            halt  <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
            addr  <= '0;
            data  <= 8'd0;
            valid <= 1'b0;
            last  <= 1'b0;
            rr    <= 1'b0;
            drop  <= 1'b0;
`ifdef JT900H_DMPCTL_CHKSUM_EN
            sum   <= 8'd0;
            chk   <= 1'b0;
`endif
        end else if (cen) begin
            state <= state_nx;
            gnt   <= gnt_nx;
            halt  <= halt_nx;
            done  <= done_nx;
            abort <= abort_nx;
            addr  <= addr_nx;
            data  <= data_nx;
            valid <= valid_nx;
            last  <= last_nx;
            rr    <= rr_nx;
            drop  <= drop_nx;
`ifdef JT900H_DMPCTL_CHKSUM_EN
            sum   <= sum_nx;
            chk   <= chk_nx;
`endif
        end
    end
endmodule

// File: tb/tb_jt900h_dmpctl.sv
// Directed bench for jt900h_dmpctl: reset, full dump, arbitration, backpressure/cen, aborts
// and, when JT900H_DMPCTL_CHKSUM_EN is defined, the checksum byte.
module tb_jt900h_dmpctl;
    localparam int DMP_LAST = 81;
    localparam int AW       = 8;
`ifdef JT900H_DMPCTL_CHKSUM_EN
    localparam int NB = DMP_LAST + 2;
`else
    localparam int NB = DMP_LAST + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic       halt, done, abort;
    logic       halted;
    logic       auto_ack = 1'b1;
    logic [7:0] rf [0:255];
    int         vectors = 0;
    int         miscompares = 0;

    jt900h_dmpctl_if #(.AW(AW)) dif ();
    assign dif.dmp_dout = rf[dif.dmp_addr];

    jt900h_dmpctl #(.DMP_LAST(DMP_LAST), .AW(AW)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .req    (req),
        .gnt    (gnt),
        .halt   (halt),
        .halted (halted),
        .done   (done),
        .abort  (abort),
        .dmp    (dif)
    );

    always #5 clk = ~clk;

    // CPU model: acknowledges the freeze one cycle after halt
    always @(posedge clk or negedge rst_n)
        if (!rst_n) halted <= 1'b0;
        else        halted <= auto_ack & halt;

    function automatic logic [7:0] pat(input int n);
        return 8'((n * 3 + 17) & 255);
    endfunction

    function automatic logic [7:0] exp_byte(input int n);
        logic [7:0] s;
        if (n <= DMP_LAST) return pat(n);
        s = 8'd0;
        for (int i = 0; i <= DMP_LAST; i++) s = s + pat(i);
        return 8'd0 - s;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit found;
        step();
        vectors++;
        if ({gnt, halt, dif.dmp_addr, dif.st_data, dif.st_valid, dif.st_last, done, abort} !== '0) begin
            miscompares++;
            $display("FAIL reset_init: got gnt=%b halt=%b addr=%0d data=%h v=%b l=%b done=%b abort=%b want all 0",
                     gnt, halt, dif.dmp_addr, dif.st_data, dif.st_valid, dif.st_last, done, abort);
        end
        rst_n = 1'b1;
        req = 2'b01;
        dif.st_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            step();
            if (dif.st_valid && dif.dmp_addr == 8'd40) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL reset_reach40: got no byte at addr 40 want one within 500 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({gnt, halt, dif.dmp_addr, dif.st_data, dif.st_valid, dif.st_last, done, abort} !== '0) begin
            miscompares++;
            $display("FAIL reset_middump: got gnt=%b halt=%b addr=%0d data=%h v=%b l=%b done=%b abort=%b want all 0",
                     gnt, halt, dif.dmp_addr, dif.st_data, dif.st_valid, dif.st_last, done, abort);
        end
        req = 2'b00;
        step();
        rst_n = 1'b1;
        repeat (5) step();
        vectors++;
        if ({gnt, halt, dif.st_valid, done, abort} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got gnt=%b halt=%b v=%b done=%b abort=%b want all 0",
                     gnt, halt, dif.st_valid, done, abort);
        end
    endtask

    task automatic test_full_dump();
        int n, cyc, first_cyc, done_cyc, ndone;
        n = 0; cyc = 0; first_cyc = -1; done_cyc = -1; ndone = 0;
        req = 2'b01; cen = 1'b1; dif.st_ready = 1'b1;
        while (done_cyc < 0 && cyc < 1000) begin
            step();
            cyc++;
            if (dif.st_valid && first_cyc < 0) first_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                ndone++;
                req = 2'b00;
                vectors++;
                if (halt !== 1'b0 || gnt !== 2'b00) begin
                    miscompares++;
                    $display("FAIL full_release: got halt=%b gnt=%b want 0 00", halt, gnt);
                end
            end
            if (dif.st_valid) begin
                vectors++;
                if (dif.st_data !== exp_byte(n)) begin
                    miscompares++;
                    $display("FAIL full_byte%0d: got %h want %h", n, dif.st_data, exp_byte(n));
                end
                vectors++;
                if (dif.st_last !== (n == NB - 1)) begin
                    miscompares++;
                    $display("FAIL full_last%0d: got %b want %b", n, dif.st_last, (n == NB - 1));
                end
                if (n == NB - 1) begin
                    vectors++;
                    if (halt !== 1'b1 || gnt !== 2'b01) begin
                        miscompares++;
                        $display("FAIL full_hold: got halt=%b gnt=%b want 1 01", halt, gnt);
                    end
                end
                n++;
            end
        end
        vectors++;
        if (done_cyc < 0) begin
            miscompares++;
            $display("FAIL full_timeout: got no done want done within 1000 cycles");
        end
        vectors++;
        if (n != NB) begin
            miscompares++;
            $display("FAIL full_count: got %0d bytes want %0d", n, NB);
        end
        vectors++;
        if (done_cyc - first_cyc != 2 * NB) begin
            miscompares++;
            $display("FAIL full_cycles: got %0d want %0d", done_cyc - first_cyc, 2 * NB);
        end
        repeat (3) begin
            step();
            if (done) ndone++;
        end
        vectors++;
        if (ndone != 1 || gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL full_done_once: got %0d pulses gnt=%b want 1 pulse gnt=00", ndone, gnt);
        end
    endtask

    task automatic test_arb();
        bit seen;
        reset_dut();
        req = 2'b11; dif.st_ready = 1'b1;
        step();
        vectors++;
        if (gnt !== 2'b01) begin
            miscompares++;
            $display("FAIL arb_first: got %b want 01", gnt);
        end
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL arb_done1: got no done want done within 1000 cycles");
        end
        step();
        vectors++;
        if (gnt !== 2'b10 || halt !== 1'b1) begin
            miscompares++;
            $display("FAIL arb_second: got gnt=%b halt=%b want 10 1", gnt, halt);
        end
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            step();
            if (done) begin
                seen = 1'b1;
                req = 2'b00;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL arb_done2: got no done want done within 1000 cycles");
        end
        step();
        vectors++;
        if (gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL arb_idle: got %b want 00", gnt);
        end
    endtask

    task automatic test_backpressure();
        int  n;
        bit  pending, stalled, got_done;
        n = 0; pending = 1'b0; stalled = 1'b0; got_done = 1'b0;
        req = 2'b01; cen = 1'b1; dif.st_ready = 1'b0;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            step();
            if (done) begin
                got_done = 1'b1;
                req = 2'b00;
            end
            if (pending) begin
                vectors++;
                if (dif.st_valid !== 1'b1 || dif.st_data !== exp_byte(n)) begin
                    miscompares++;
                    $display("FAIL bp_stable%0d: got v=%b data=%h want v=1 data=%h",
                             n, dif.st_valid, dif.st_data, exp_byte(n));
                end
            end
            if (!stalled && dif.st_valid && n == 30) begin
                stalled = 1'b1;
                cen = 1'b0;
                dif.st_ready = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    step();
                    vectors++;
                    if (dif.st_valid !== 1'b1 || dif.st_data !== exp_byte(30) ||
                        dif.dmp_addr !== 8'd30 || halt !== 1'b1) begin
                        miscompares++;
                        $display("FAIL bp_cen%0d: got v=%b data=%h addr=%0d halt=%b want 1 %h 30 1",
                                 k, dif.st_valid, dif.st_data, dif.dmp_addr, halt, exp_byte(30));
                    end
                end
                cen = 1'b1;
            end
            dif.st_ready = 1'($urandom_range(0, 1));
            if (dif.st_valid && dif.st_ready) begin
                vectors++;
                if (dif.st_data !== exp_byte(n) || dif.st_last !== (n == NB - 1)) begin
                    miscompares++;
                    $display("FAIL bp_byte%0d: got %h last=%b want %h last=%b",
                             n, dif.st_data, dif.st_last, exp_byte(n), (n == NB - 1));
                end
                n++;
                pending = 1'b0;
            end else begin
                pending = dif.st_valid;
            end
        end
        dif.st_ready = 1'b1;
        vectors++;
        if (!got_done || n != NB) begin
            miscompares++;
            $display("FAIL bp_count: got done=%b bytes=%0d want done=1 bytes=%0d", got_done, n, NB);
        end
    endtask

    task automatic test_abort_strm();
        int nb;
        bit found, saw_last;
        nb = 0; found = 1'b0; saw_last = 1'b0;
        req = 2'b01; cen = 1'b1; dif.st_ready = 1'b1;
        for (int i = 0; i < 500 && !found; i++) begin
            step();
            if (dif.st_last) saw_last = 1'b1;
            if (dif.st_valid) begin
                if (dif.dmp_addr == 8'd10) begin
                    found = 1'b1;
                    dif.st_ready = 1'b0;
                    req = 2'b00;
                end else begin
                    nb++;
                end
            end
        end
        step();
        vectors++;
        if (!found || dif.st_valid !== 1'b1 || dif.st_data !== exp_byte(10) || abort !== 1'b0) begin
            miscompares++;
            $display("FAIL abs_held: got found=%b v=%b data=%h abort=%b want 1 1 %h 0",
                     found, dif.st_valid, dif.st_data, abort, exp_byte(10));
        end
        dif.st_ready = 1'b1;
        step();
        vectors++;
        if (abort !== 1'b1 || halt !== 1'b0 || gnt !== 2'b00 || dif.st_valid !== 1'b0 ||
            dif.st_last !== 1'b0 || dif.dmp_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL abs_pulse: got abort=%b halt=%b gnt=%b v=%b l=%b addr=%0d want 1 0 00 0 0 0",
                     abort, halt, gnt, dif.st_valid, dif.st_last, dif.dmp_addr);
        end
        step();
        vectors++;
        if (abort !== 1'b0 || nb != 10 || saw_last) begin
            miscompares++;
            $display("FAIL abs_after: got abort=%b bytes_before=%0d saw_last=%b want 0 10 0",
                     abort, nb, saw_last);
        end
    endtask

    task automatic test_abort_halt();
        auto_ack = 1'b0;
        req = 2'b01;
        step();
        vectors++;
        if (gnt !== 2'b01 || halt !== 1'b1) begin
            miscompares++;
            $display("FAIL abh_grant: got gnt=%b halt=%b want 01 1", gnt, halt);
        end
        step();
        req = 2'b00;
        step();
        vectors++;
        if (abort !== 1'b1 || halt !== 1'b0 || gnt !== 2'b00 || dif.st_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abh_pulse: got abort=%b halt=%b gnt=%b v=%b want 1 0 00 0",
                     abort, halt, gnt, dif.st_valid);
        end
        step();
        vectors++;
        if (abort !== 1'b0 || dif.st_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abh_after: got abort=%b v=%b want 0 0", abort, dif.st_valid);
        end
        auto_ack = 1'b1;
    endtask

`ifdef JT900H_DMPCTL_CHKSUM_EN
    task automatic test_chksum();
        int n, last_idx;
        logic [7:0] s, final_byte;
        bit got_done;
        for (int i = 0; i < DMP_LAST; i++) rf[i] = 8'(i);
        rf[DMP_LAST] = 8'h8F;
        n = 0; last_idx = -1; s = 8'd0; final_byte = 8'd0; got_done = 1'b0;
        req = 2'b01; dif.st_ready = 1'b1;
        for (int cyc = 0; cyc < 1000 && !got_done; cyc++) begin
            step();
            if (done) begin
                got_done = 1'b1;
                req = 2'b00;
            end
            if (dif.st_valid) begin
                s = s + dif.st_data;
                final_byte = dif.st_data;
                if (dif.st_last) last_idx = n;
                n++;
            end
        end
        vectors++;
        if (n != DMP_LAST + 2 || final_byte !== 8'hC9) begin
            miscompares++;
            $display("FAIL chk_byte: got bytes=%0d final=%h want %0d C9", n, final_byte, DMP_LAST + 2);
        end
        vectors++;
        if (last_idx != DMP_LAST + 1 || s !== 8'h00) begin
            miscompares++;
            $display("FAIL chk_sum: got last_idx=%0d sum=%h want %0d 00", last_idx, s, DMP_LAST + 1);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) rf[i] = pat(i);
        dif.st_ready = 1'b0;
        test_reset();
        test_full_dump();
        test_arb();
        test_backpressure();
        test_abort_strm();
        test_abort_halt();
`ifdef JT900H_DMPCTL_CHKSUM_EN
        test_chksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
